// File: rtl/dmem_responder.sv
// Data-memory responder: LSU target with byte-lane writes, wait states,
// a stall back to the pipeline and a one-cycle response strobe.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic        stall
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = 4;
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic            lat_wr;
    logic [3:0]      lat_mask;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_data;
    logic            lat_in_range;

    logic [31:0]     mem [DEPTH];

    logic [31:0]     off_c;
    logic            in_range_c;
    logic [AW-1:0]   idx_c;
    logic            accept_c;

    logic            acc_c;
    logic            acc_wr;
    logic [3:0]      acc_mask;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_data;
    logic            acc_in_range;

    logic            unused_ok;

    // Range check and word index of the live request
    always_comb begin
        off_c      = addr - BASE_ADDR;
        in_range_c = ({1'b0, off_c} < SPAN);
        idx_c      = off_c[AW+1:2];
        accept_c   = !cs && ((state == IDLE) || (state == RESP));
    end

    // Byte offset within the word is irrelevant for word access
    assign unused_ok = ^off_c[1:0];

    // Access strobe and operands: live inputs without wait states, latched copy otherwise
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            acc_c        = accept_c;
            acc_wr       = wr;
            acc_mask     = mask;
            acc_idx      = idx_c;
            acc_data     = data_wr;
            acc_in_range = in_range_c;
        end else begin
            acc_c        = (state == BUSY) && (cnt == '0);
            acc_wr       = lat_wr;
            acc_mask     = lat_mask;
            acc_idx      = lat_idx;
            acc_data     = lat_data;
            acc_in_range = lat_in_range;
        end
    end

    // Byte-lane store into the array; a reset edge drops the pending write
    always_ff @(posedge clk) begin
        if (!rst && acc_c && !acc_wr && acc_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
                end
            end
        end
    end

    // Request FSM, wait counter, request latch and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            data_rd      <= '0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            stall        <= 1'b0;
            lat_wr       <= 1'b1;
            lat_mask     <= '0;
            lat_idx      <= '0;
            lat_data     <= '0;
            lat_in_range <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;

            case (state)
                IDLE, RESP: begin
                    if (accept_c) begin
                        lat_wr       <= wr;
                        lat_mask     <= mask;
                        lat_idx      <= idx_c;
                        lat_data     <= data_wr;
                        lat_in_range <= in_range_c;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                            stall <= 1'b0;
                        end else begin
                            state <= BUSY;
                            cnt   <= CW'(WAIT_CYCLES - 1);
                            stall <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        stall <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        stall <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            endcase

            if (acc_c) begin
                rsp_valid <= 1'b1;
                rsp_err   <= !acc_in_range;
                if (acc_wr) begin
                    data_rd <= acc_in_range ? mem[acc_idx] : 32'h0;
                end
            end
        end
    end

endmodule
